// File: rtl/dma_xfer_ctrl_pkg.sv
// Shared definitions for the DMA copy sequencer.
//   - dma_xfer_state_e : sequencer state encoding
//   - BEAT_BYTES / PAGE_BYTES / PAGE_BEATS : beat and page geometry
//   - SIZE_64BIT / BE_FULL : fixed request attributes
//   - dma_desc_t : copy descriptor (source, destination, beat count)
package dma_pkg;

  localparam int unsigned BEAT_BYTES = 8;
  localparam int unsigned PAGE_BYTES = 4096;
  // A 4 KiB page holds 512 beats of 8 bytes.
  localparam int unsigned PAGE_BEATS = PAGE_BYTES / BEAT_BYTES;

  localparam logic [2:0] SIZE_64BIT = 3'd3;
  localparam logic [7:0] BE_FULL    = 8'hFF;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CALC    = 3'd1,
    S_RD_REQ  = 3'd2,
    S_RD_WAIT = 3'd3,
    S_WR_REQ  = 3'd4,
    S_WR_WAIT = 3'd5,
    S_DONE    = 3'd6
  } dma_xfer_state_e;

  typedef struct packed {
    logic [63:0] src;
    logic [63:0] dst;
    logic [15:0] beats;
  } dma_desc_t;

endpackage

// File: rtl/dma_xfer_ctrl_if.sv
// Request/response bus between the copy sequencer and dma_axi_adapter.
// Signal names are written from the sequencer's point of view.
//   req_o/type_o/addr_o/we_o/be_o/len_o/size_o/id_o : request fields
//   gnt_i                                           : request accepted
//   valid_i/rid_i                                   : transaction complete + ID
//
// Handshake: a request is presented with req_o=1 and all fields held stable
// until the cycle gnt_i=1; that edge consumes it. Completion is a single
// cycle valid_i=1, attributed to this sequencer only when rid_i matches its
// ID. Only one request is ever in flight.
interface dma_xfer_ctrl_if #(
  parameter int AXI_ADDR_WIDTH = 64,
  parameter int AXI_ID_WIDTH   = 10,
  parameter int AXI_LEN_WIDTH  = 8
);
  logic                      req_o;
  logic                      type_o;
  logic                      gnt_i;
  logic [AXI_ADDR_WIDTH-1:0] addr_o;
  logic                      we_o;
  logic [7:0]                be_o;
  logic [AXI_LEN_WIDTH-1:0]  len_o;
  logic [2:0]                size_o;
  logic [AXI_ID_WIDTH-1:0]   id_o;
  logic                      valid_i;
  logic [AXI_ID_WIDTH-1:0]   rid_i;

  modport master (
    output req_o, type_o, addr_o, we_o, be_o, len_o, size_o, id_o,
    input  gnt_i, valid_i, rid_i
  );

  modport slave (
    input  req_o, type_o, addr_o, we_o, be_o, len_o, size_o, id_o,
    output gnt_i, valid_i, rid_i
  );
endinterface

// File: rtl/dma_xfer_ctrl_chunk_calc.sv
// Chunk size calculator: chunk = min(rem, MAX_BEATS, beats left in the
// source page, beats left in the destination page). Purely combinational.
//   src_off_i : source beat offset within its 4 KiB page (addr[11:3])
//   dst_off_i : destination beat offset within its page
//   rem_i     : beats still to copy (non-zero when used)
//   chunk_o   : beats in the next chunk, 1..512
// CNT_WIDTH must be at least 10.
module dma_chunk_calc
  import dma_pkg::*;
#(
  parameter int CNT_WIDTH = 16,
  parameter int MAX_BEATS = 256
) (
  input  logic [8:0]           src_off_i,
  input  logic [8:0]           dst_off_i,
  input  logic [CNT_WIDTH-1:0] rem_i,
  output logic [9:0]           chunk_o
);

  // A chunk can never exceed a page, so the limit is clipped to 512 to fit
  // the 10-bit page arithmetic.
  localparam logic [9:0] MAX_LIM =
    (MAX_BEATS > int'(PAGE_BEATS)) ? 10'(PAGE_BEATS) : 10'(MAX_BEATS);

  logic [9:0] src_room;
  logic [9:0] dst_room;

  // Room is 1..512; an offset of 0 means the whole page is available.
  assign src_room = 10'(PAGE_BEATS) - {1'b0, src_off_i};
  assign dst_room = 10'(PAGE_BEATS) - {1'b0, dst_off_i};

  always_comb begin
    chunk_o = src_room;
    if (dst_room < chunk_o) chunk_o = dst_room;
    if (MAX_LIM < chunk_o)  chunk_o = MAX_LIM;
    if (32'(rem_i) < 32'(chunk_o)) chunk_o = rem_i[9:0];
  end

endmodule

// File: rtl/dma_xfer_ctrl.sv
// Descriptor-driven copy sequencer in front of dma_axi_adapter.
// Splits a descriptor into chunks bounded by MAX_BEATS and 4 KiB pages on
// both sides; each chunk is a read burst into the adapter buffer followed by
// a write burst out of it.
//   clk_i, rst_ni               : clock, async active-low reset
//   desc_valid_i/desc_ready_o   : descriptor handshake (ready = idle)
//   desc_src_i/desc_dst_i       : byte addresses, bits [2:0] ignored
//   desc_beats_i                : beats to copy (0 completes immediately)
//   busy_o                      : descriptor in progress
//   done_o                      : one-cycle completion pulse
//   dbg_state_o                 : current sequencer state
//   req_if                      : adapter request bus (master side)
// The interface instance must use the same width parameters as this module.
module dma_xfer_ctrl
  import dma_pkg::*;
#(
  parameter int AXI_ADDR_WIDTH = 64,
  parameter int AXI_ID_WIDTH   = 10,
  parameter int AXI_LEN_WIDTH  = 8,
  parameter int MAX_BEATS      = 256,
  parameter int CNT_WIDTH      = 16,
  parameter int XFER_ID        = 0
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      desc_valid_i,
  output logic                      desc_ready_o,
  input  logic [AXI_ADDR_WIDTH-1:0] desc_src_i,
  input  logic [AXI_ADDR_WIDTH-1:0] desc_dst_i,
  input  logic [CNT_WIDTH-1:0]      desc_beats_i,
  output logic                      busy_o,
  output logic                      done_o,
  output dma_xfer_state_e           dbg_state_o,
  dma_xfer_ctrl_if.master           req_if
);

  localparam logic [AXI_ADDR_WIDTH-1:0] BEAT_MASK = ~AXI_ADDR_WIDTH'(BEAT_BYTES - 1);

  dma_xfer_state_e           state_q;
  logic [AXI_ADDR_WIDTH-1:0] src_q, dst_q;
  logic [CNT_WIDTH-1:0]      rem_q;
  logic [9:0]                chunk_q;
  logic                      desc_ready_q, busy_q, done_q;
  logic                      req_q, we_q, type_q;
  logic [AXI_ADDR_WIDTH-1:0] addr_q;
  logic [AXI_LEN_WIDTH-1:0]  len_q;

  logic [9:0]                chunk_d;
  logic                      rsp_match;
  logic                      rd_finish, wr_finish;
  logic [AXI_ADDR_WIDTH-1:0] step;

  dma_chunk_calc #(
    .CNT_WIDTH (CNT_WIDTH),
    .MAX_BEATS (MAX_BEATS)
  ) u_chunk_calc (
    .src_off_i (src_q[11:3]),
    .dst_off_i (dst_q[11:3]),
    .rem_i     (rem_q),
    .chunk_o   (chunk_d)
  );

  assign rsp_match = req_if.valid_i && (req_if.rid_i == AXI_ID_WIDTH'(XFER_ID));

  // A completion arriving in the same cycle as the grant finishes the
  // request phase directly, skipping the wait state.
  assign rd_finish = rsp_match && ((state_q == S_RD_WAIT) ||
                                   (state_q == S_RD_REQ && req_if.gnt_i));
  assign wr_finish = rsp_match && ((state_q == S_WR_WAIT) ||
                                   (state_q == S_WR_REQ && req_if.gnt_i));

  // Byte distance covered by the current chunk; addresses wrap silently.
  assign step = AXI_ADDR_WIDTH'({chunk_q, 3'b000});

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= S_IDLE;
      src_q        <= '0;
      dst_q        <= '0;
      rem_q        <= '0;
      chunk_q      <= '0;
      desc_ready_q <= 1'b1;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      req_q        <= 1'b0;
      we_q         <= 1'b0;
      type_q       <= 1'b0;
      addr_q       <= '0;
      len_q        <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (desc_valid_i) begin
            src_q        <= desc_src_i & BEAT_MASK;
            dst_q        <= desc_dst_i & BEAT_MASK;
            rem_q        <= desc_beats_i;
            desc_ready_q <= 1'b0;
            busy_q       <= 1'b1;
            if (desc_beats_i == '0) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= S_CALC;
            end
          end
        end
        S_CALC: begin
          // len/type stay valid for both the read and the write of a chunk.
          chunk_q <= chunk_d;
          req_q   <= 1'b1;
          we_q    <= 1'b0;
          addr_q  <= src_q;
          len_q   <= AXI_LEN_WIDTH'(chunk_d - 10'd1);
          type_q  <= (chunk_d == 10'd1);
          state_q <= S_RD_REQ;
        end
        S_RD_REQ, S_RD_WAIT: begin
          if (state_q == S_RD_REQ && req_if.gnt_i) req_q <= 1'b0;
          if (rd_finish) begin
            req_q   <= 1'b1;
            we_q    <= 1'b1;
            addr_q  <= dst_q;
            state_q <= S_WR_REQ;
          end else if (state_q == S_RD_REQ && req_if.gnt_i) begin
            state_q <= S_RD_WAIT;
          end
        end
        S_WR_REQ, S_WR_WAIT: begin
          if (state_q == S_WR_REQ && req_if.gnt_i) req_q <= 1'b0;
          if (wr_finish) begin
            src_q <= src_q + step;
            dst_q <= dst_q + step;
            rem_q <= rem_q - CNT_WIDTH'(chunk_q);
            if (rem_q == CNT_WIDTH'(chunk_q)) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= S_CALC;
            end
          end else if (state_q == S_WR_REQ && req_if.gnt_i) begin
            state_q <= S_WR_WAIT;
          end
        end
        S_DONE: begin
          state_q      <= S_IDLE;
          busy_q       <= 1'b0;
          desc_ready_q <= 1'b1;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign desc_ready_o  = desc_ready_q;
  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign dbg_state_o   = state_q;

  assign req_if.req_o  = req_q;
  assign req_if.we_o   = we_q;
  assign req_if.type_o = type_q;
  assign req_if.addr_o = addr_q;
  assign req_if.len_o  = len_q;
  assign req_if.be_o   = BE_FULL;
  assign req_if.size_o = SIZE_64BIT;
  assign req_if.id_o   = AXI_ID_WIDTH'(XFER_ID);

endmodule

// File: tb/tb_dma_xfer_ctrl.sv
// Bench for dma_xfer_ctrl: acts as the adapter, checks every request against
// a chunk list computed from the copy rules, and checks completion timing.
module tb_dma_xfer_ctrl;
  import dma_pkg::*;

  localparam int AW = 64;
  localparam int IW = 10;
  localparam int LW = 8;
  localparam int MB = 256;
  localparam int CW = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst_n;
  logic            desc_valid;
  logic            desc_ready;
  logic [AW-1:0]   desc_src;
  logic [AW-1:0]   desc_dst;
  logic [CW-1:0]   desc_beats;
  logic            busy;
  logic            done;
  dma_xfer_state_e dbg_state;

  dma_xfer_ctrl_if #(.AXI_ADDR_WIDTH(AW), .AXI_ID_WIDTH(IW), .AXI_LEN_WIDTH(LW)) bus ();

  dma_xfer_ctrl #(
    .AXI_ADDR_WIDTH (AW),
    .AXI_ID_WIDTH   (IW),
    .AXI_LEN_WIDTH  (LW),
    .MAX_BEATS      (MB),
    .CNT_WIDTH      (CW),
    .XFER_ID        (0)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .desc_valid_i (desc_valid),
    .desc_ready_o (desc_ready),
    .desc_src_i   (desc_src),
    .desc_dst_i   (desc_dst),
    .desc_beats_i (desc_beats),
    .busy_o       (busy),
    .done_o       (done),
    .dbg_state_o  (dbg_state),
    .req_if       (bus)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int passes = 0;
  // Entry layout: {we, type, len[7:0], addr[63:0]}
  logic [73:0] exp_q[$];

  // Reference: walk the copy in page/MAX_BEATS-limited pieces.
  task automatic model_push(input logic [63:0] src, input logic [63:0] dst, input int beats);
    logic [63:0] s, d;
    int r, c, sr, dr;
    s = src & ~64'h7;
    d = dst & ~64'h7;
    r = beats;
    while (r > 0) begin
      sr = (4096 - int'(s % 64'd4096)) / 8;
      dr = (4096 - int'(d % 64'd4096)) / 8;
      c = r;
      if (c > MB) c = MB;
      if (sr < c) c = sr;
      if (dr < c) c = dr;
      exp_q.push_back({1'b0, (c == 1), 8'(c - 1), s});
      exp_q.push_back({1'b1, (c == 1), 8'(c - 1), d});
      s = s + 64'(c * 8);
      d = d + 64'(c * 8);
      r = r - c;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // ---------------- driver: one descriptor + adapter behaviour ----------------
  task automatic run_desc(input logic [63:0] src, input logic [63:0] dst, input logic [15:0] beats,
                          input int gnt_lo, input int gnt_hi, input bit stress);
    logic [73:0] exp, snap;
    int t, dly;
    bit same, aborted;
    exp_q.delete();
    model_push(src, dst, int'(beats));
    @(negedge clk);
    checks++;
    if (desc_ready !== 1'b1) $display("FAIL desc_ready_idle got=%b exp=1", desc_ready);
    else passes++;
    desc_valid = 1'b1; desc_src = src; desc_dst = dst; desc_beats = beats;
    @(negedge clk);
    desc_valid = 1'b0;
    checks++;
    if (busy !== 1'b1 || desc_ready !== 1'b0 || bus.req_o !== 1'b0)
      $display("FAIL accept got busy=%b ready=%b req=%b exp 1/0/0", busy, desc_ready, bus.req_o);
    else passes++;
    aborted = 1'b0;
    while (exp_q.size() > 0 && !aborted) begin
      t = 0;
      while (bus.req_o !== 1'b1 && t < 100) begin @(negedge clk); t++; end
      if (bus.req_o !== 1'b1) begin
        checks++;
        $display("FAIL req_timeout got req=%b exp=1 within 100 cycles", bus.req_o);
        aborted = 1'b1;
      end else begin
        exp  = exp_q.pop_front();
        snap = {bus.we_o, bus.type_o, bus.len_o, bus.addr_o};
        checks++;
        if (snap !== exp || done !== 1'b0)
          $display("FAIL req_fields got=%h done=%b exp=%h done=0", snap, done, exp);
        else passes++;
        checks++;
        if ({bus.be_o, bus.size_o, bus.id_o} !== {8'hFF, 3'd3, 10'd0})
          $display("FAIL req_const got be=%h size=%0d id=%0d exp ff/3/0", bus.be_o, bus.size_o, bus.id_o);
        else passes++;
        dly = $urandom_range(gnt_hi, gnt_lo);
        for (int i = 0; i < dly; i++) begin
          if (stress) begin
            desc_valid = 1'b1; desc_src = {$urandom, $urandom}; desc_dst = 64'h0; desc_beats = 16'd5;
          end
          @(negedge clk);
          checks++;
          if ({bus.req_o, bus.we_o, bus.type_o, bus.len_o, bus.addr_o} !== {1'b1, snap} || desc_ready !== 1'b0)
            $display("FAIL req_stable got=%h ready=%b exp=%h ready=0",
                     {bus.req_o, bus.we_o, bus.type_o, bus.len_o, bus.addr_o}, desc_ready, {1'b1, snap});
          else passes++;
        end
        desc_valid = 1'b0;
        same = ($urandom_range(0, 3) == 0) && !stress;
        bus.gnt_i = 1'b1;
        if (same) begin bus.valid_i = 1'b1; bus.rid_i = '0; end
        @(negedge clk);
        bus.gnt_i = 1'b0; bus.valid_i = 1'b0;
        if (!same) begin
          dly = stress ? $urandom_range(1, 3) : $urandom_range(0, 3);
          for (int i = 0; i < dly; i++) begin
            if (stress && i == 0) begin bus.valid_i = 1'b1; bus.rid_i = IW'(1 + $urandom_range(0, 1000)); end
            @(negedge clk);
            bus.valid_i = 1'b0;
            checks++;
            if (bus.req_o !== 1'b0 || done !== 1'b0)
              $display("FAIL wait_quiet got req=%b done=%b exp 0/0", bus.req_o, done);
            else passes++;
          end
          bus.valid_i = 1'b1; bus.rid_i = '0;
          @(negedge clk);
          bus.valid_i = 1'b0;
        end
      end
    end
    if (aborted) begin
      do_reset();
    end else begin
      checks++;
      if (done !== 1'b1) $display("FAIL done_rise got=%b exp=1", done);
      else passes++;
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || busy !== 1'b0 || desc_ready !== 1'b1)
        $display("FAIL done_pulse got done=%b busy=%b ready=%b exp 0/0/1", done, busy, desc_ready);
      else passes++;
      repeat (3) begin
        @(negedge clk);
        checks++;
        if (bus.req_o !== 1'b0 || busy !== 1'b0 || done !== 1'b0)
          $display("FAIL idle_quiet got req=%b busy=%b done=%b exp 0/0/0", bus.req_o, busy, done);
        else passes++;
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (desc_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || bus.req_o !== 1'b0 ||
        bus.we_o !== 1'b0 || bus.addr_o !== 64'h0 || bus.len_o !== 8'h0 || bus.type_o !== 1'b0 ||
        dbg_state !== S_IDLE)
      $display("FAIL reset_values got ready=%b busy=%b done=%b req=%b we=%b addr=%h len=%h type=%b",
               desc_ready, busy, done, bus.req_o, bus.we_o, bus.addr_o, bus.len_o, bus.type_o);
    else passes++;
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (desc_ready !== 1'b1 || busy !== 1'b0 || bus.req_o !== 1'b0)
      $display("FAIL reset_release got ready=%b busy=%b req=%b exp 1/0/0", desc_ready, busy, bus.req_o);
    else passes++;
  endtask

  task automatic test_single_chunk(); run_desc(64'h1000, 64'h2000, 16'd4, 0, 2, 1'b0);   endtask
  task automatic test_single_beat();  run_desc(64'h0,    64'h100,  16'd1, 0, 2, 1'b0);   endtask
  task automatic test_page_split();   run_desc(64'h1FF0, 64'h3000, 16'd8, 0, 2, 1'b0);   endtask
  task automatic test_max_beats();    run_desc(64'h0,    64'h10000, 16'd300, 0, 1, 1'b0); endtask
  task automatic test_gnt_stall();    run_desc(64'h5000, 64'h6008, 16'd4, 10, 10, 1'b1); endtask
  task automatic test_zero_beats();   run_desc(64'h7000, 64'h8000, 16'd0, 0, 0, 1'b0);   endtask

  task automatic test_reset_mid();
    int t;
    @(negedge clk);
    desc_valid = 1'b1; desc_src = 64'h4000; desc_dst = 64'h9000; desc_beats = 16'd16;
    @(negedge clk);
    desc_valid = 1'b0;
    t = 0;
    while (bus.req_o !== 1'b1 && t < 20) begin @(negedge clk); t++; end
    bus.gnt_i = 1'b1;
    @(negedge clk);
    bus.gnt_i = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b1 || bus.req_o !== 1'b0)
      $display("FAIL rd_wait_entry got busy=%b req=%b exp 1/0", busy, bus.req_o);
    else passes++;
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if (desc_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || bus.req_o !== 1'b0 ||
        bus.we_o !== 1'b0 || bus.addr_o !== 64'h0 || bus.len_o !== 8'h0 || bus.type_o !== 1'b0)
      $display("FAIL reset_mid got ready=%b busy=%b done=%b req=%b we=%b addr=%h len=%h type=%b",
               desc_ready, busy, done, bus.req_o, bus.we_o, bus.addr_o, bus.len_o, bus.type_o);
    else passes++;
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (bus.req_o !== 1'b0 || busy !== 1'b0 || desc_ready !== 1'b1)
        $display("FAIL reset_mid_idle got req=%b busy=%b ready=%b exp 0/0/1", bus.req_o, busy, desc_ready);
      else passes++;
    end
  endtask

  task automatic test_random();
    logic [63:0] s, d;
    logic [15:0] b;
    for (int n = 0; n < 14; n++) begin
      s = {$urandom, $urandom};
      d = {$urandom, $urandom};
      if ($urandom_range(0, 1) == 1) s = (s & ~64'hFFF) | 64'(4096 - 8 * $urandom_range(1, 8));
      if ($urandom_range(0, 1) == 1) d = (d & ~64'hFFF) | 64'(4096 - 8 * $urandom_range(1, 8) + $urandom_range(0, 7));
      b = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 3)) : 16'($urandom_range(1, 600));
      run_desc(s, d, b, 0, 3, 1'b0);
    end
    // Source and destination wrap past the top of the address space.
    run_desc(64'hFFFF_FFFF_FFFF_FFF0, 64'hFFFF_FFFF_FFFF_FFE0, 16'd6, 0, 2, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0;
    desc_valid = 1'b0; desc_src = '0; desc_dst = '0; desc_beats = '0;
    bus.gnt_i = 1'b0; bus.valid_i = 1'b0; bus.rid_i = '0;
    test_reset();
    test_single_chunk();
    test_single_beat();
    test_page_split();
    test_max_beats();
    test_gnt_stall();
    test_zero_beats();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
